mux_rr4: RTL and testbench
==========================

MUX_RR4 -- requirements
Module: mux_rr4

Interface
REQ-001 FIFO_DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid_in  input  4  per-lane write strobe; bit i qualifies data_in_i.
REQ-005 data_in_0 .. data_in_3  input  8 each  lane payload bytes.
REQ-006 ready_out  output  4  bit i high when lane i FIFO is not full.
REQ-007 valid_out  output  1  data_out/control carry a byte this cycle; feeds the downstream demux valid_in.
REQ-008 data_out  output  8  interleaved byte stream; feeds demux data_in.
REQ-009 control  output  8  [1:0] source lane index, [7:2] 6-bit emitted-byte sequence number.
REQ-010 overflow  output  4  sticky per-lane drop flag.

Function
REQ-011 Each lane SHALL own a FIFO_DEPTH-entry FIFO with a count register of width log2(FIFO_DEPTH)+1.
REQ-012 Write: valid_in[i]=1 and count_i<FIFO_DEPTH at an edge SHALL store data_in_i and increment count_i.
REQ-013 Write to a full lane (count_i==FIFO_DEPTH) SHALL drop the byte and set overflow[i]; this applies even if the same lane is popped that edge.
REQ-014 ready_out[i] SHALL equal (count_i != FIFO_DEPTH), decoded from registers only.
REQ-015 Arbiter SHALL keep a 2-bit pointer last_grant; each cycle it SHALL search lanes last_grant+1, +2, +3, +4 (mod 4) and select the first with count>0.
REQ-016 FSM states: IDLE, SEND.
REQ-017 IDLE: if any count>0, at the edge pop the selected lane, register its head byte into data_out, set valid_out=1, go to SEND; else stay, valid_out=0.
REQ-018 SEND: if any count>0, pop the next selected lane each edge (one byte per clock, back-to-back); else valid_out=0 and go to IDLE.
REQ-019 On each pop, last_grant SHALL update to the popped lane and control[1:0] SHALL equal that lane.
REQ-020 control[7:2] SHALL increment by 1 per emitted byte, wrapping 63 -> 0; its value with the first byte after reset SHALL be 0.
REQ-021 Latency: a byte written to an empty lane at edge N, with no other lane pending, SHALL appear with valid_out=1 after edge N+1.
REQ-022 Simultaneous write and pop on the same lane SHALL leave count unchanged and preserve FIFO order.
REQ-023 Write visibility: a byte written at edge N SHALL NOT be eligible for arbitration at edge N.
REQ-024 Per-lane order SHALL be strictly FIFO; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 When valid_out=0, data_out and control SHALL hold their last values.
REQ-026 With all four lanes continuously non-empty, grant order SHALL be 0,1,2,3,0,... starting after the reset value of last_grant.
REQ-027 overflow bits SHALL clear only on reset.

Reset
REQ-028 reset=1 SHALL immediately force valid_out=0, data_out=0x00, control=0x00, overflow=0, all counts and pointers to 0, last_grant=3, state IDLE, regardless of clk.
REQ-029 ready_out SHALL be 4'b1111 while reset is asserted and after release.
REQ-030 Reset asserted mid-stream SHALL discard all buffered bytes; the first byte after release SHALL carry sequence number 0.
REQ-031 Writes on the first edge after reset deassertion SHALL be accepted normally.

Verification
REQ-032 Single byte: reset release, valid_in=0001, data_in_0=0xA5 for one edge -> after the next edge valid_out=1, data_out=0xA5, control=0x00; valid_out returns to 0 one cycle later.
REQ-033 Fairness: preload each lane with 2 bytes (lane i: 0x10*i, 0x10*i+1) -> output 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31; control[1:0]=0,1,2,3,0,1,2,3 on consecutive cycles.
REQ-034 Overflow: write 5 bytes back-to-back to lane 2 with FIFO_DEPTH=4 while lanes 0,1,3 are busy -> ready_out[2]=0 after the 4th write, 5th byte dropped, overflow=0100, only 4 lane-2 bytes emitted.
REQ-035 Sequence wrap: stream 65 bytes on lane 1 -> control[7:2] runs 0..63, then 0 on byte 65.
REQ-036 Reset mid-operation: assert reset asynchronously between edges with 3 lanes holding data -> outputs go to 0 immediately; after release, no stale bytes emitted; next written byte carries control[7:2]=0.

Source files
------------

// File: rtl/mux_rr4.sv
// mux_rr4: four-lane byte multiplexer.
// Each lane buffers bytes in a small FIFO. A round-robin arbiter drains the
// lanes into one interleaved stream, one byte per clock. control[1:0] carries
// the source lane and control[7:2] a running 6-bit sequence number.
module mux_rr4 #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] valid_in,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic [7:0] data_in_2,
  input  logic [7:0] data_in_3,
  output logic [3:0] ready_out,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic [7:0] control,
  output logic [3:0] overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PONE  = AW'(1);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  // Lane storage and bookkeeping
  logic [7:0]    r_mem    [4][FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr [4];
  logic [AW-1:0] r_rd_ptr [4];
  logic [AW:0]   r_count  [4];

  logic [1:0]    r_last_grant;
  logic [5:0]    r_seq;
  state_t        r_state;
  logic          r_valid_out;
  logic [7:0]    r_data_out;
  logic [7:0]    r_control;
  logic [3:0]    r_overflow;

  logic [7:0]    w_din     [4];
  logic [3:0]    w_nonempty;
  logic [3:0]    w_full;
  logic [3:0]    w_wr_acc;
  logic [3:0]    w_pop_vec;
  logic          w_any;
  logic          w_found;
  logic [1:0]    w_sel;
  logic          w_pop;
  state_t        w_state_next;

  assign w_din[0] = data_in_0;
  assign w_din[1] = data_in_1;
  assign w_din[2] = data_in_2;
  assign w_din[3] = data_in_3;

  assign ready_out = ~w_full;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign control   = r_control;
  assign overflow  = r_overflow;

  // Per-lane status decoded from the count registers only
  always_comb begin
    w_nonempty = '0;
    w_full     = '0;
    w_wr_acc   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_nonempty[i] = (r_count[i] != '0);
      w_full[i]     = (r_count[i] == FULL);
      w_wr_acc[i]   = valid_in[i] && (r_count[i] != FULL);
    end
  end

  assign w_any = |w_nonempty;

  // Round-robin search starting just after the last granted lane
  always_comb begin
    w_sel   = r_last_grant;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!w_found && w_nonempty[2'(r_last_grant + 2'(k))]) begin
        w_found = 1'b1;
        w_sel   = 2'(r_last_grant + 2'(k));
      end
    end
  end

  // FSM next-state and pop decision
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_pop        = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (w_any) begin
          w_pop = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_pop_vec = w_pop ? (4'b0001 << w_sel) : 4'b0000;

  // FIFO payload storage; contents need no reset because counts gate reads
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_wr_acc[i]) begin
        r_mem[i][r_wr_ptr[i]] <= w_din[i];
      end
    end
  end

  // Pointers, counts, sticky overflow flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wr_acc[i]) begin
          r_wr_ptr[i] <= r_wr_ptr[i] + PONE;
        end
        if (valid_in[i] && w_full[i]) begin
          r_overflow[i] <= 1'b1;
        end
        if (w_pop_vec[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + PONE;
        end
        if (w_wr_acc[i] && !w_pop_vec[i]) begin
          r_count[i] <= r_count[i] + CONE;
        end else if (!w_wr_acc[i] && w_pop_vec[i]) begin
          r_count[i] <= r_count[i] - CONE;
        end
      end
    end
  end

  // FSM state, arbiter pointer and registered output stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 2'd3;
      r_seq        <= '0;
      r_valid_out  <= 1'b0;
      r_data_out   <= '0;
      r_control    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_valid_out  <= 1'b1;
        r_data_out   <= r_mem[w_sel][r_rd_ptr[w_sel]];
        r_control    <= {r_seq, w_sel};
        r_seq        <= r_seq + 6'd1;
        r_last_grant <= w_sel;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr4.sv
// Testbench for mux_rr4: scenario tasks push expected {data, control} words
// into a scoreboard queue; a negedge monitor pops and compares each output.
module tb_mux_rr4;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valid_in;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] ready_out;
  logic       valid_out;
  logic [7:0] data_out;
  logic [7:0] control;
  logic [3:0] overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb[$];
  logic [15:0] mon_exp;
  logic [5:0]  exp_seq;
  logic [7:0]  last_d;
  logic [7:0]  last_c;

  mux_rr4 #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in_0 (d0),
    .data_in_1 (d1),
    .data_in_2 (d2),
    .data_in_3 (d3),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .control   (control),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Output monitor: scoreboard compare on valid, hold check otherwise
  always @(negedge clk) begin
    if (reset) begin
      last_d = '0;
      last_c = '0;
    end else if (valid_out) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got data %02h ctrl %02h, expected no output", data_out, control);
      end else begin
        mon_exp = sb.pop_front();
        if ({data_out, control} !== mon_exp) begin
          errors++;
          $display("FAIL stream: got data %02h ctrl %02h, expected data %02h ctrl %02h",
                   data_out, control, mon_exp[15:8], mon_exp[7:0]);
        end
      end
      last_d = data_out;
      last_c = control;
    end else begin
      checks++;
      if (data_out !== last_d || control !== last_c) begin
        errors++;
        $display("FAIL hold: got data %02h ctrl %02h, expected data %02h ctrl %02h",
                 data_out, control, last_d, last_c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] lane, input logic [7:0] data);
    sb.push_back({data, exp_seq, lane});
    exp_seq = exp_seq + 6'd1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_seq = '0;
    sb.delete();
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) step();
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    valid_in = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    exp_seq  = '0;
    #2;
    checks++;
    if ({valid_out, data_out, control, overflow} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%02h c=%02h ovf=%b, expected all zero",
               valid_out, data_out, control, overflow);
    end
    checks++;
    if (ready_out !== 4'b1111) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1111", ready_out);
    end
    do_reset();
  endtask

  task automatic test_single_byte();
    valid_in = 4'b0001;
    d0       = 8'hA5;
    push(2'd0, 8'hA5);
    step();
    valid_in = '0;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got valid_out %b expected 0", valid_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hA5 || control !== 8'h00) begin
      errors++;
      $display("FAIL single_byte: got v=%b d=%02h c=%02h expected v=1 d=a5 c=00",
               valid_out, data_out, control);
    end
    step();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got valid_out %b expected 0", valid_out);
    end
    wait_drain();
  endtask

  task automatic test_fairness();
    logic [1:0] lane;
    do_reset();
    valid_in = 4'b1111;
    d0 = 8'h00; d1 = 8'h10; d2 = 8'h20; d3 = 8'h30;
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 4; l++) push(2'(l), 8'(16 * l + b));
    step();
    d0 = 8'h01; d1 = 8'h11; d2 = 8'h21; d3 = 8'h31;
    step();
    valid_in = '0;
    for (int i = 0; i < 8; i++) begin
      lane = 2'(i);
      checks++;
      if (valid_out !== 1'b1 || control[1:0] !== lane) begin
        errors++;
        $display("FAIL fair_grant%0d: got v=%b lane=%0d expected v=1 lane=%0d",
                 i, valid_out, control[1:0], lane);
      end
      step();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL fair_end: got valid_out %b expected 0", valid_out);
    end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL fair_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push(2'd2, 8'h2F);
    push(2'd3, 8'h3A);
    push(2'd0, 8'h0A);
    push(2'd1, 8'h1A);
    for (int k = 0; k < 4; k++) push(2'd2, 8'(8'h20 + k));
    valid_in = 4'b0100; d2 = 8'h2F;
    step();
    valid_in = 4'b1111;
    d0 = 8'h0A; d1 = 8'h1A; d2 = 8'h20; d3 = 8'h3A;
    step();
    valid_in = 4'b0100; d2 = 8'h21;
    step();
    d2 = 8'h22;
    step();
    checks++;
    if (ready_out !== 4'b1111) begin
      errors++;
      $display("FAIL ovf_ready3: got %b expected 1111", ready_out);
    end
    d2 = 8'h23;
    step();
    checks++;
    if (ready_out !== 4'b1011 || overflow !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_full: got ready %b ovf %b expected ready 1011 ovf 0000", ready_out, overflow);
    end
    d2 = 8'h24;
    step();
    valid_in = '0;
    checks++;
    if (overflow !== 4'b0100 || ready_out !== 4'b1111) begin
      errors++;
      $display("FAIL ovf_drop: got ovf %b ready %b expected ovf 0100 ready 1111", overflow, ready_out);
    end
    wait_drain();
    checks++;
    if (sb.size() != 0 || overflow !== 4'b0100) begin
      errors++;
      $display("FAIL ovf_sticky: got pending %0d ovf %b expected 0 and 0100", sb.size(), overflow);
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    valid_in = 4'b0010;
    for (int i = 0; i < 65; i++) begin
      d1 = 8'(i * 3 + 1);
      push(2'd1, d1);
      step();
    end
    valid_in = '0;
    step();
    checks++;
    if (control !== {6'd0, 2'd1} || data_out !== 8'(64 * 3 + 1)) begin
      errors++;
      $display("FAIL seq_wrap: got ctrl %02h data %02h expected ctrl 01 data %02h",
               control, data_out, 8'(64 * 3 + 1));
    end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL seq_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    push(2'd0, 8'h40);
    push(2'd1, 8'h50);
    valid_in = 4'b0111;
    d0 = 8'h40; d1 = 8'h50; d2 = 8'h60;
    step();
    d0 = 8'h41; d1 = 8'h51; d2 = 8'h61;
    step();
    d0 = 8'h42; d1 = 8'h52; d2 = 8'h62;
    step();
    valid_in = '0;
    #6;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mid_pre: got %0d pending expected 0", sb.size());
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({valid_out, data_out, control, overflow} !== 21'd0 || ready_out !== 4'b1111) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%02h c=%02h ovf=%b rdy=%b expected zeros, rdy 1111",
               valid_out, data_out, control, overflow, ready_out);
    end
    sb.delete();
    exp_seq = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    valid_in = 4'b1000;
    d3       = 8'h77;
    push(2'd3, 8'h77);
    step();
    valid_in = '0;
    wait_drain();
    repeat (6) step();
    checks++;
    if (sb.size() != 0 || last_c !== 8'h03) begin
      errors++;
      $display("FAIL mid_after: got pending %0d last ctrl %02h expected 0 and 03", sb.size(), last_c);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fairness();
    test_overflow();
    test_seq_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
